// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, word/index types and writeback FSM states for the register file write port.
package regfile_pkg;
  localparam int NUM_REGS = 16;
  localparam int REG_AW = 4;
  localparam int DW = 16;
  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] word_t;
  typedef enum logic {INIT, RUN} wb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way writeback grant with a round-robin tie pointer or fixed A priority.
module rr_arb2 #(
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);
  logic rr_ptr;
  always_comb begin
    a_gnt = a_req && (!b_req || PRIORITY_MODE || !rr_ptr);
    b_gnt = b_req && !a_gnt;
  end
  // Pointer moves only on a contested grant and lands on the loser (0 = A, 1 = B).
  always_ff @(posedge clk or negedge rst)
    if (!rst) rr_ptr <= 1'b0;
    else if (en && a_req && b_req) rr_ptr <= a_gnt;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole owner of the register file write port; zero sweep after reset, then arbitrated A/B writeback.
module regfile_wb_arbiter #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int REG_AW = regfile_pkg::REG_AW,
  parameter int DW = regfile_pkg::DW,
  parameter bit INIT_CLEAR = 1'b1,
  parameter bit ZERO_PROTECT = 1'b1,
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_reg,
  input  logic [DW-1:0]     a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_reg,
  input  logic [DW-1:0]     b_data,
  output logic              WriteReg,
  output logic [REG_AW-1:0] DstReg,
  output logic [DW-1:0]     DstData,
  output logic [NUM_REGS-1:0] pend_vec,
  output logic              init_done
);
  import regfile_pkg::*;
  localparam logic [REG_AW:0] LAST_CNT = (REG_AW+1)'(NUM_REGS);
  wb_state_t state, next_state;
  logic [REG_AW:0] init_cnt;
  logic init_last, a_gnt, b_gnt, a_take, b_take, xfer;
  logic [REG_AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  rr_arb2 #(.PRIORITY_MODE(PRIORITY_MODE)) u_arb (
    .clk(clk),
    .rst(rst),
    .en(state == RUN),
    .a_req(a_valid),
    .b_req(b_valid),
    .a_gnt(a_gnt),
    .b_gnt(b_gnt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= INIT_CLEAR ? INIT : RUN;
    else state <= next_state;
  assign init_last = init_cnt == LAST_CNT;
  always_comb next_state = (state == INIT && init_last) ? RUN : state;
  // Ready is masked by reset so it drops at once even when no sweep is configured.
  always_comb begin
    a_take = state == RUN && a_gnt;
    b_take = state == RUN && b_gnt;
    a_ready = rst && a_take;
    b_ready = rst && b_take;
    xfer = a_take || b_take;
    wr_reg = a_take ? a_reg : b_reg;
    wr_data = a_take ? a_data : b_data;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      WriteReg <= 1'b0;
      DstReg <= '0;
      DstData <= '0;
      init_cnt <= '0;
      init_done <= !INIT_CLEAR;
    end else if (state == INIT) begin
      WriteReg <= !init_last;
      DstReg <= init_last ? DstReg : init_cnt[REG_AW-1:0];
      DstData <= '0;
      init_cnt <= init_last ? init_cnt : init_cnt + (REG_AW+1)'(1);
      init_done <= init_last;
    end else begin
      WriteReg <= xfer && !(ZERO_PROTECT && wr_reg == '0);
      DstReg <= xfer ? wr_reg : DstReg;
      DstData <= xfer ? wr_data : DstData;
    end
  always_comb pend_vec = WriteReg ? NUM_REGS'(1) << DstReg : '0;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: two configurations (round-robin + zero protect, fixed priority + no protect) against a cycle model.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0, rst = 1'b0, a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0] a_reg = '0, b_reg = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic [1:0] ar, br, we, idone;
  logic [3:0] dreg [2];
  logic [15:0] ddata [2];
  logic [15:0] pv [2];
  logic [15:0] rf [2][16];
  int n_cmp = 0, n_bad = 0;
  bit m_run [2], m_tie [2], m_we [2];
  int m_cnt [2];
  logic [3:0] m_reg [2];
  logic [15:0] m_data [2];
  logic [15:0] m_mem [2][16];
  logic [1:0] last_ga, last_gb;
  int na [2], nb [2];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    regfile_wb_arbiter #(.ZERO_PROTECT(k == 0), .PRIORITY_MODE(k == 1)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(ar[k]), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(br[k]), .b_reg(b_reg), .b_data(b_data),
      .WriteReg(we[k]), .DstReg(dreg[k]), .DstData(ddata[k]),
      .pend_vec(pv[k]), .init_done(idone[k])
    );
  end
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (we[k]) rf[k][dreg[k]] <= ddata[k];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_cnt[k] = 0; m_tie[k] = 0; m_we[k] = 0; m_reg[k] = '0; m_data[k] = '0;
    end
  endtask
  task automatic check_rf(int k);
    for (int i = 0; i < 16; i++) check("regfile", rf[k][i], m_mem[k][i]);
  endtask
  // One clock: check grants before the edge, advance the model, check registered outputs after it.
  task automatic cyc();
    logic [1:0] ga, gb;
    #1;
    for (int k = 0; k < 2; k++) begin
      ga[k] = m_run[k] && a_valid && (!b_valid || k == 1 || !m_tie[k]);
      gb[k] = m_run[k] && b_valid && !ga[k];
      check("a_ready", ar[k], ga[k]);
      check("b_ready", br[k], gb[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (m_we[k]) m_mem[k][m_reg[k]] = m_data[k];
      if (!m_run[k]) begin
        m_cnt[k]++;
        m_run[k] = m_cnt[k] > 16;
        m_we[k] = !m_run[k];
        if (m_we[k]) begin
          m_reg[k] = 4'(m_cnt[k] - 1);
          m_data[k] = '0;
        end
      end else begin
        m_we[k] = 0;
        if (ga[k] || gb[k]) begin
          m_reg[k] = ga[k] ? a_reg : b_reg;
          m_data[k] = ga[k] ? a_data : b_data;
          m_we[k] = !(k == 0 && m_reg[k] == 4'd0);
          if (a_valid && b_valid) m_tie[k] = ga[k];
        end
      end
    end
    last_ga = ga;
    last_gb = gb;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("WriteReg", we[k], m_we[k]);
      check("pend_vec", pv[k], m_we[k] ? 16'(1) << m_reg[k] : 16'h0);
      check("init_done", idone[k], m_run[k]);
      if (m_we[k]) begin
        check("DstReg", dreg[k], m_reg[k]);
        check("DstData", ddata[k], m_data[k]);
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) m_mem[k][i] = 'x;
    model_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_we", we[k], 0);
      check("rst_dreg", dreg[k], 0);
      check("rst_ddata", ddata[k], 0);
      check("rst_done", idone[k], 0);
      check("rst_pend", pv[k], 0);
      check("rst_ardy", ar[k], 0);
      check("rst_brdy", br[k], 0);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b1;
    repeat (17) cyc();
    for (int k = 0; k < 2; k++) begin
      check("sweep_done", idone[k], 1);
      for (int i = 0; i < 16; i++) check("sweep_zero", rf[k][i], 16'h0);
    end
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'hBEEF;
    cyc();
    for (int k = 0; k < 2; k++) check("pend_r3", pv[k], 16'h0008);
    a_valid = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) check("rf_r3", rf[k][3], 16'hBEEF);
    a_valid = 1'b1; a_reg = 4'd5; a_data = 16'h1111;
    b_valid = 1'b1; b_reg = 4'd5; b_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (last_ga[0]) a_valid = 1'b0;
      if (last_gb[0]) b_valid = 1'b0;
    end
    for (int k = 0; k < 2; k++) check("rf_r5_last", rf[k][5], 16'h2222);
    a_valid = 1'b1; a_reg = 4'd0; a_data = 16'hFFFF;
    cyc();
    a_valid = 1'b0;
    repeat (2) cyc();
    check("zero_protect", rf[0][0], 16'h0000);
    check("zero_open", rf[1][0], 16'hFFFF);
    a_valid = 1'b1;
    b_valid = 1'b1;
    na = '{0, 0};
    nb = '{0, 0};
    for (int i = 0; i < 8; i++) begin
      a_reg = 4'($urandom_range(1, 15)); a_data = 16'($urandom);
      b_reg = 4'($urandom_range(1, 15)); b_data = 16'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        na[k] += int'(ar[k]);
        nb[k] += int'(br[k]);
      end
      cyc();
    end
    check("rr_a_grants", na[0], 4);
    check("rr_b_grants", nb[0], 4);
    check("prio_a_grants", na[1], 8);
    check("prio_b_grants", nb[1], 0);
    for (int i = 0; i < 300; i++) begin
      if (!a_valid || last_ga[0]) begin
        a_valid = 1'($urandom_range(0, 1)); a_reg = 4'($urandom); a_data = 16'($urandom);
      end
      if (!b_valid || last_gb[0]) begin
        b_valid = 1'($urandom_range(0, 1)); b_reg = 4'($urandom); b_data = 16'($urandom);
      end
      cyc();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) cyc();
    check_rf(0);
    check_rf(1);
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1234;
    cyc();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("mid_rst_we", we[k], 0);
      check("mid_rst_ardy", ar[k], 0);
      check("mid_rst_brdy", br[k], 0);
      check("mid_rst_done", idone[k], 0);
      check("mid_rst_pend", pv[k], 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_valid = 1'b0;
    repeat (17) cyc();
    for (int k = 0; k < 2; k++) begin
      check("rf_r3_cleared", rf[k][3], 16'h0000);
      check_rf(k);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
